lzx_74hc191_counter: RTL and testbench



---
 rtl/lzx_gate_pkg.sv | 8 +
 rtl/lzx_hc191_stage.sv | 22 ++
 rtl/lzx_74hc191_counter.sv | 62 ++++++
 tb/tb_lzx_74hc191_counter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/lzx_gate_pkg.sv
// Shared constants for the gate-library counter blocks: direction encoding and default width.
package lzx_gate_pkg;

   localparam logic LZX_DIR_UP    = 1'b0;
   localparam logic LZX_DIR_DN    = 1'b1;
   localparam int   LZX_CNT_WIDTH = 4;

endpackage

// File: rtl/lzx_hc191_stage.sv
// One counter bit: loads d when ld is high, otherwise toggles when tog is high.
module lzx_hc191_stage
   import lzx_gate_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic tog,
   input  logic ld,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= 1'b0;
      else if (ld)
         q <= d;
      else if (tog)
         q <= ~q;
   end

endmodule

// File: rtl/lzx_74hc191_counter.sv
// 74HC191-style synchronous presettable up/down counter with terminal count.
// Define LZX_HC191_RC_EN to add the registered active-low ripple-clock output nRC.
module lzx_74hc191_counter
   import lzx_gate_pkg::*;
#(
   parameter int WIDTH = LZX_CNT_WIDTH
)(
   input  logic             Clk,
   input  logic             Rd,
   input  logic             nCE,
   input  logic             DnU,
   input  logic             nPL,
   input  logic [WIDTH-1:0] D,
`ifdef LZX_HC191_RC_EN
   output logic             nRC,
`endif
   output logic [WIDTH-1:0] Q,
   output logic             TC
);

   logic [WIDTH-1:0] q_bits;
   logic [WIDTH-1:0] tog;
   logic [WIDTH-1:0] low_mask;

   // A bit toggles when every lower bit sits at the extreme for the current direction.
   always_comb begin
      tog      = '0;
      low_mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (DnU == LZX_DIR_DN)
            tog[i] = ~nCE & ((q_bits & low_mask) == '0);
         else
            tog[i] = ~nCE & ((q_bits & low_mask) == low_mask);
         low_mask[i] = 1'b1;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_stage
      lzx_hc191_stage u_stage (
         .clk (Clk),
         .rst (Rd),
         .tog (tog[g]),
         .ld  (~nPL),
         .d   (D[g]),
         .q   (q_bits[g])
      );
   end

   assign Q  = q_bits;
   assign TC = (DnU == LZX_DIR_DN) ? (q_bits == '0) : (&q_bits);

`ifdef LZX_HC191_RC_EN
   // Low for one cycle after an edge that counted through the terminal value.
   always_ff @(posedge Clk or posedge Rd) begin
      if (Rd)
         nRC <= 1'b1;
      else
         nRC <= ~(TC & ~nCE & nPL);
   end
`endif

endmodule

// File: tb/tb_lzx_74hc191_counter.sv
// Self-checking bench for lzx_74hc191_counter: directed steps with a scoreboard of expected Q/TC/nRC.
module tb_lzx_74hc191_counter;
   import lzx_gate_pkg::*;

   logic       Clk = 1'b0;
   logic       Rd  = 1'b1;
   logic       nCE = 1'b1;
   logic       DnU = 1'b0;
   logic       nPL = 1'b1;
   logic [3:0] D   = 4'h0;
   logic [3:0] Q;
   logic       TC;
   logic       nRC;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      tag;
      logic [3:0] q;
      logic       tc;
      logic       rcn;
   } exp_t;

   exp_t sb[$];

   logic [3:0] mq  = 4'h0;
   logic       mrc = 1'b1;

   always #5 Clk = ~Clk;

   lzx_74hc191_counter #(.WIDTH(4)) dut (
      .Clk (Clk),
      .Rd  (Rd),
      .nCE (nCE),
      .DnU (DnU),
      .nPL (nPL),
      .D   (D),
`ifdef LZX_HC191_RC_EN
      .nRC (nRC),
`endif
      .Q   (Q),
      .TC  (TC)
   );

`ifndef LZX_HC191_RC_EN
   assign nRC = 1'b1;
`endif

   function automatic logic modelTc(input logic [3:0] q, input logic dnu);
      return (dnu == LZX_DIR_DN) ? (q == 4'h0) : (q == 4'hF);
   endfunction

   task automatic pushExp(input string tag);
      exp_t e;
      e.tag = tag;
      e.q   = mq;
      e.tc  = modelTc(mq, DnU);
      e.rcn = mrc;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_empty observed=0 expected=entry");
         return;
      end
      e = sb.pop_front();
      total++;
      assert (Q === e.q) else begin
         bad++;
         $error("[TB] FAIL %s.Q observed=%h expected=%h", e.tag, Q, e.q);
      end
      total++;
      assert (TC === e.tc) else begin
         bad++;
         $error("[TB] FAIL %s.TC observed=%b expected=%b", e.tag, TC, e.tc);
      end
`ifdef LZX_HC191_RC_EN
      total++;
      assert (nRC === e.rcn) else begin
         bad++;
         $error("[TB] FAIL %s.nRC observed=%b expected=%b", e.tag, nRC, e.rcn);
      end
`endif
   endtask

   // Drive controls away from the edge, predict the next state, then check after the edge.
   task automatic applyStimulus(input logic nce, input logic dnu, input logic npl,
                                input logic [3:0] d, input string tag);
      logic tc_pre;
      @(negedge Clk);
      nCE = nce;
      DnU = dnu;
      nPL = npl;
      D   = d;
      tc_pre = modelTc(mq, dnu);
      mrc    = ~(tc_pre & ~nce & npl);
      if (!npl)
         mq = d;
      else if (!nce)
         mq = (dnu == LZX_DIR_DN) ? mq - 4'h1 : mq + 4'h1;
      pushExp(tag);
      @(posedge Clk);
      #1;
      checkOutput();
   endtask

   task automatic checkNow(input string tag);
      #1;
      pushExp(tag);
      checkOutput();
   endtask

   initial begin
      $display("[TB] start");

      // Reset state with both directions.
      #2;
      checkNow("reset_up");
      DnU = LZX_DIR_DN;
      checkNow("reset_dn_tc");
      DnU = LZX_DIR_UP;

      // Count to 9, then assert Rd between edges.
      @(negedge Clk);
      Rd = 1'b0;
      applyStimulus(1'b1, LZX_DIR_UP, 1'b0, 4'h7, "load7");
      applyStimulus(1'b0, LZX_DIR_UP, 1'b1, 4'h0, "cnt8");
      applyStimulus(1'b0, LZX_DIR_UP, 1'b1, 4'h0, "cnt9");
      #2;
      Rd  = 1'b1;
      mq  = 4'h0;
      mrc = 1'b1;
      checkNow("rd_async");
      @(posedge Clk);
      checkNow("rd_held");

      // Release with counting enabled up.
      #2;
      Rd = 1'b0;
      applyStimulus(1'b0, LZX_DIR_UP, 1'b1, 4'h0, "release_cnt1");

      // Up-count wrap.
      applyStimulus(1'b1, LZX_DIR_UP, 1'b0, 4'hE, "up_loadE");
      applyStimulus(1'b0, LZX_DIR_UP, 1'b1, 4'h0, "up_F");
      applyStimulus(1'b0, LZX_DIR_UP, 1'b1, 4'h0, "up_wrap0");
      applyStimulus(1'b0, LZX_DIR_UP, 1'b1, 4'h0, "up_1");

      // Down-count wrap.
      applyStimulus(1'b1, LZX_DIR_DN, 1'b0, 4'h1, "dn_load1");
      applyStimulus(1'b0, LZX_DIR_DN, 1'b1, 4'h0, "dn_0");
      applyStimulus(1'b0, LZX_DIR_DN, 1'b1, 4'h0, "dn_wrapF");
      applyStimulus(1'b0, LZX_DIR_DN, 1'b1, 4'h0, "dn_E");

      // Load beats count; then hold.
      applyStimulus(1'b0, LZX_DIR_UP, 1'b0, 4'h5, "prio_load5");
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, LZX_DIR_UP, 1'b1, 4'hA, "hold5");
      applyStimulus(1'b1, LZX_DIR_UP, 1'b0, 4'h5, "load_same");

      // Direction change at the extreme.
      applyStimulus(1'b1, LZX_DIR_UP, 1'b0, 4'hF, "dir_loadF");
      #2;
      DnU = LZX_DIR_DN;
      checkNow("dir_flip_tc");
      applyStimulus(1'b0, LZX_DIR_DN, 1'b1, 4'h0, "dir_cntE");

      // Randomised tail exercising mixed controls against the model.
      for (int i = 0; i < 24; i++)
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), "rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
